half_exp_accum: RTL and testbench
=================================

HALF_EXP_ACCUM -- requirements
Module: half_exp_accum

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the maximum number of vector elements buffered for replay.
REQ-002 The block SHALL have parameter AW, default 4, giving the buffer address width, with DEPTH = 2**AW.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input element is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-007 The block SHALL have port in_last, input, 1 bit: the accepted element ends the vector.
REQ-008 The block SHALL have port a, input, 16 bits: IEEE half-precision exp() value from the upstream exp stage.
REQ-009 The block SHALL have port sum_valid, output, 1 bit: one-cycle pulse when sum is final.
REQ-010 The block SHALL have port sum, output, 16 bits: half-precision sum of the vector, held until the next vector starts.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a replayed element is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream (divider) accepts the replayed element.
REQ-013 The block SHALL have port out_last, output, 1 bit: the replayed element is the final one.
REQ-014 The block SHALL have port c, output, 16 bits: the replayed element value.
REQ-015 The block SHALL have port count, output, AW+1 bits: number of elements stored for the current vector.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky per vector; the sum reached infinity.
REQ-017 The block SHALL have port error, output, 1 bit: sticky per vector; the vector exceeded DEPTH or contained a negative input.

Function
REQ-018 Additions SHALL use one instance of the existing half_add (rstn, clk, in_valid, a, b, out_valid, c), with rstn driven by ~rst; the block SHALL NOT assume a fixed adder latency.
REQ-019 FSM states SHALL be IDLE, WAIT_ADD and REPLAY.
REQ-020 IDLE: in_ready = 1; an element is accepted when in_valid & in_ready.
REQ-021 Accepting the first element of a vector SHALL clear the accumulator to 0x0000, count, overflow and error in the same cycle.
REQ-022 On accept, the block SHALL issue half_add(acc, a') for one cycle and go to WAIT_ADD; a' = a, or 0x0000 with error set if a[15] = 1.
REQ-023 On accept with count < DEPTH, a' SHALL be written to buffer[count] and count incremented.
REQ-024 On accept with count = DEPTH, a' SHALL be summed but not stored, and error set.
REQ-025 WAIT_ADD: in_ready = 0; on adder out_valid, acc <= adder c.
REQ-026 If adder c[14:10] = 5'b11111, acc SHALL be forced to 0x7C00 and overflow set; acc remains 0x7C00 for the rest of the vector.
REQ-027 After an add, if the accepted element had in_last = 1: sum <= acc result, sum_valid pulses one cycle, next state is REPLAY; otherwise next state is IDLE.
REQ-028 REPLAY: out_valid = 1, c = buffer[rd_ptr], out_last = (rd_ptr = count-1); rd_ptr advances on out_valid & out_ready.
REQ-029 Transfer with out_last SHALL return the FSM to IDLE with rd_ptr = 0.
REQ-030 c and out_last SHALL hold stable while out_valid & !out_ready.
REQ-031 in_ready SHALL be 0 in WAIT_ADD and REPLAY, so a new vector cannot start until replay completes.
REQ-032 A single-element vector SHALL replay one element, with out_last = 1 on the first beat.
REQ-033 in_valid SHALL be ignored while in_ready = 0; the upstream holds data.

Reset
REQ-034 While rst is high, the FSM SHALL be IDLE and in_ready = 1 once rst is released.
REQ-035 While rst is high, the following SHALL be 0: sum_valid, out_valid, out_last, sum, c, count, overflow, error, acc, rd_ptr.
REQ-036 Reset mid-vector or mid-replay SHALL discard the vector; an adder result in flight SHALL be dropped.
REQ-037 Buffer contents need not be reset.

Verification
REQ-038 Scenario 1: vector 0x3C00, 0x3C00, 0x3C00 (last) -> sum 0x4200 with one sum_valid pulse; replay 3C00 x3 with out_last on the third beat; count = 3.
REQ-039 Scenario 2: single element 0x4000 with in_last -> sum 0x4000, one replay beat with out_last = 1, back to IDLE.
REQ-040 Scenario 3: 0x7800 + 0x7800 (last) -> sum 0x7C00, overflow = 1, error = 0.
REQ-041 Scenario 4: 17 elements of 0x3C00 -> error = 1, count = 16, sum 0x4C40, exactly 16 replay beats.
REQ-042 Scenario 5: out_ready toggled randomly during replay -> no beat lost or duplicated, c stable while stalled; element 0xBC00 -> summed and replayed as 0x0000 with error = 1.
REQ-043 Scenario 6: rst asserted during WAIT_ADD and again during REPLAY -> all outputs 0 immediately; the next vector 0x3C00 (last) gives sum 0x3C00.

Source files
------------

// File: rtl/half_exp_accum.sv
// Softmax denominator stage: sums a vector of non-negative half-precision
// exp() values, then replays the buffered elements to the divider.
// Contains the shared half_add adder used for the accumulation.

// Half-precision adder for non-negative operands, two-cycle pipeline.
// Rounds to nearest even; results at or above 2^16 saturate to +inf.
// Operands with the sign bit set are treated as zero.
module half_add (
    input  logic        rstn,
    input  logic        clk,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] c
);
    logic        stage_valid;
    logic [15:0] stage_sum;

    function automatic logic [15:0] add_pos(input logic [15:0] p_in, input logic [15:0] q_in);
        logic [15:0] p, q;
        logic [4:0]  ep, eq, ex, ey, d;
        logic [10:0] mp, mq, mx, my, m;
        logic [23:0] xf, yf, ys;
        logic [24:0] s;
        logic [11:0] mr;
        logic [5:0]  e;
        logic        st, g, sb;
        p  = p_in[15] ? 16'h0000 : p_in;
        q  = q_in[15] ? 16'h0000 : q_in;
        // Subnormals use the minimum exponent with no hidden bit.
        ep = (p[14:10] == 5'd0) ? 5'd1 : p[14:10];
        eq = (q[14:10] == 5'd0) ? 5'd1 : q[14:10];
        mp = {|p[14:10], p[9:0]};
        mq = {|q[14:10], q[9:0]};
        if (ep >= eq) begin
            ex = ep; mx = mp; ey = eq; my = mq;
        end else begin
            ex = eq; mx = mq; ey = ep; my = mp;
        end
        d  = ex - ey;
        xf = {mx, 13'd0};
        yf = {my, 13'd0};
        ys = yf >> d;
        st = ((ys << d) != yf);
        s  = {1'b0, xf} + {1'b0, ys};
        if (s[24]) begin
            m  = s[24:14];
            g  = s[13];
            sb = (|s[12:0]) | st;
            e  = {1'b0, ex} + 6'd1;
        end else begin
            m  = s[23:13];
            g  = s[12];
            sb = (|s[11:0]) | st;
            e  = {1'b0, ex};
        end
        mr = {1'b0, m} + {11'd0, g & (sb | m[0])};
        if (mr[11]) begin
            m = mr[11:1];
            e = e + 6'd1;
        end else begin
            m = mr[10:0];
        end
        if (e >= 6'd31) return 16'h7C00;
        // A result without the hidden bit is still subnormal.
        return {1'b0, m[10] ? e[4:0] : 5'd0, m[9:0]};
    endfunction

    // Two register stages: computed sum, then output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_valid <= 1'b0;
            stage_sum   <= 16'h0000;
            out_valid   <= 1'b0;
            c           <= 16'h0000;
        end else begin
            stage_valid <= in_valid;
            stage_sum   <= add_pos(a, b);
            out_valid   <= stage_valid;
            c           <= stage_sum;
        end
    end
endmodule

module half_exp_accum #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [15:0]   a,
    output logic          sum_valid,
    output logic [15:0]   sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [15:0]   c,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          error
);
    typedef enum logic [1:0] {IDLE, WAIT_ADD, REPLAY} state_t;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    state_t        state;
    logic [15:0]   buffer [DEPTH];
    logic [15:0]   acc;
    logic [AW-1:0] rd_ptr;
    logic          fresh;        // next accepted element starts a new vector
    logic          last_pending; // element now in the adder closed its vector
    logic          add_in_valid;
    logic [15:0]   add_a, add_b;
    logic          add_out_valid;
    logic [15:0]   add_c;
    logic          rstn;

    logic          accept;
    logic [AW:0]   count_eff;
    logic          room;
    logic [15:0]   a_eff;
    logic          add_inf;
    logic [15:0]   add_res;

    assign rstn      = ~rst;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == REPLAY);
    assign accept    = in_valid & in_ready;
    assign count_eff = fresh ? '0 : count;
    assign room      = (count_eff < DEPTH_C);
    assign a_eff     = a[15] ? 16'h0000 : a;
    assign add_inf   = (add_c[14:10] == 5'b11111);
    assign add_res   = (overflow | add_inf) ? 16'h7C00 : add_c;
    assign c         = out_valid ? buffer[rd_ptr] : 16'h0000;
    assign out_last  = out_valid & ({1'b0, rd_ptr} == count - (AW + 1)'(1));

    half_add u_add (
        .rstn      (rstn),
        .clk       (clk),
        .in_valid  (add_in_valid),
        .a         (add_a),
        .b         (add_b),
        .out_valid (add_out_valid),
        .c         (add_c)
    );

    // Replay buffer: written on accept while there is room.
    // NOTE: storage arrays carry no reset; count and rd_ptr decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept && room) buffer[count_eff[AW-1:0]] <= a_eff;
    end

    // Control FSM: accept, wait for the adder, then replay the vector.
    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= 16'h0000;
            sum          <= 16'h0000;
            sum_valid    <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
            error        <= 1'b0;
            rd_ptr       <= '0;
            fresh        <= 1'b1;
            last_pending <= 1'b0;
            add_in_valid <= 1'b0;
            add_a        <= 16'h0000;
            add_b        <= 16'h0000;
        end else begin
            add_in_valid <= 1'b0;
            sum_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_in_valid <= 1'b1;
                        add_a        <= fresh ? 16'h0000 : acc;
                        add_b        <= a_eff;
                        last_pending <= in_last;
                        fresh        <= 1'b0;
                        overflow     <= fresh ? 1'b0 : overflow;
                        error        <= (fresh ? 1'b0 : error) | a[15] | ~room;
                        count        <= room ? count_eff + (AW + 1)'(1) : count_eff;
                        if (fresh) begin
                            acc <= 16'h0000;
                            sum <= 16'h0000;
                        end
                        state <= WAIT_ADD;
                    end
                end
                WAIT_ADD: begin
                    if (add_out_valid) begin
                        acc <= add_res;
                        if (add_inf) overflow <= 1'b1;
                        if (last_pending) begin
                            sum       <= add_res;
                            sum_valid <= 1'b1;
                            rd_ptr    <= '0;
                            fresh     <= 1'b1;
                            state     <= REPLAY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                REPLAY: begin
                    if (out_ready) begin
                        if (out_last) begin
                            rd_ptr <= '0;
                            state  <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_half_exp_accum.sv
// Scoreboard bench for half_exp_accum: expected sums and replay beats are
// queued as each vector is driven and retired as the DUT produces them.
module tb_half_exp_accum;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [15:0] sum;
        logic [AW:0] count;
        logic        ovf;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [15:0]   a = 16'h0000;
    logic          sum_valid;
    logic [15:0]   sum;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [15:0]   c;
    logic [AW:0]   count;
    logic          overflow;
    logic          error;

    int            n_cmp = 0;
    int            n_bad = 0;
    bit            rand_ready = 1'b0;
    bit            hold_ready = 1'b1;

    exp_t          exp_q[$];
    logic [16:0]   beat_q[$];
    logic [15:0]   vec_q[$];

    half_exp_accum #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a         (a),
        .sum_valid (sum_valid),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .c         (c),
        .count     (count),
        .overflow  (overflow),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Downstream readiness changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end

    // Monitor: retire sums and replay beats, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sum_valid) begin
                if (exp_q.size() == 0) begin
                    check("sum_extra", 32'(sum_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("count", 32'(count), 32'(e.count));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("error", 32'(error), 32'(e.err));
                end
            end
            if (out_valid) begin
                if (beat_q.size() == 0) begin
                    check("beat_extra", 32'(out_valid), 32'd0);
                end else begin
                    // Also covers stalls: the head stays put until accepted.
                    check("beat", 32'({out_last, c}), 32'(beat_q[0]));
                    if (out_ready) void'(beat_q.pop_front());
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_sum"},       32'(sum),       32'd0);
        check({tag, "_c"},         32'(c),         32'd0);
        check({tag, "_count"},     32'(count),     32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
    endtask

    task automatic send_elem(input logic [15:0] v, input logic l);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = v;
        in_last  = l;
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        a        = 16'h0000;
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || beat_q.size() != 0 || !in_ready) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_drained"}, 32'(exp_q.size() + beat_q.size()), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Queue expectations for vec_q, drive it, then wait for the replay to end.
    task automatic run_vec(input string tag, input logic [15:0] s, input logic [AW:0] cnt,
                           input logic ovf, input logic err);
        exp_t e;
        int   stored;
        e.sum = s; e.count = cnt; e.ovf = ovf; e.err = err;
        exp_q.push_back(e);
        stored = (vec_q.size() > DEPTH) ? DEPTH : vec_q.size();
        for (int i = 0; i < stored; i++)
            beat_q.push_back({(i == stored - 1), vec_q[i][15] ? 16'h0000 : vec_q[i]});
        for (int i = 0; i < vec_q.size(); i++)
            send_elem(vec_q[i], i == vec_q.size() - 1);
        wait_done(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero_outputs(tag);
        exp_q.delete();
        beat_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        #2;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Three ones sum to three.
        vec_q = '{16'h3C00, 16'h3C00, 16'h3C00};
        run_vec("s1", 16'h4200, 5'd3, 1'b0, 1'b0);

        // Single element vector.
        vec_q = '{16'h4000};
        run_vec("s2", 16'h4000, 5'd1, 1'b0, 1'b0);

        // Sum reaches infinity.
        vec_q = '{16'h7800, 16'h7800};
        run_vec("s3", 16'h7C00, 5'd2, 1'b1, 1'b0);

        // Seventeen ones: one past the buffer depth.
        vec_q.delete();
        for (int i = 0; i < 17; i++) vec_q.push_back(16'h3C00);
        run_vec("s4", 16'h4C40, 5'd16, 1'b0, 1'b1);

        // Negative element plus random downstream stalls.
        rand_ready = 1'b1;
        vec_q = '{16'h3C00, 16'hBC00, 16'h4000, 16'h3C00};
        run_vec("s5", 16'h4400, 5'd4, 1'b0, 1'b1);
        rand_ready = 1'b0;

        // Reset while an add is in flight.
        send_elem(16'h3C00, 1'b0);
        pulse_reset("rst_wait_add");

        // Reset while replay is stalled.
        hold_ready = 1'b0;
        exp_q.push_back('{sum: 16'h4000, count: 5'd2, ovf: 1'b0, err: 1'b0});
        beat_q.push_back({1'b0, 16'h3C00});
        beat_q.push_back({1'b1, 16'h3C00});
        send_elem(16'h3C00, 1'b0);
        send_elem(16'h3C00, 1'b1);
        budget = 0;
        while (!out_valid && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("replay_reached", 32'(out_valid), 32'd1);
        repeat (2) @(negedge clk);
        check("sum_retired", 32'(exp_q.size()), 32'd0);
        #2;
        pulse_reset("rst_replay");
        hold_ready = 1'b1;

        // Fresh vector after the resets.
        vec_q = '{16'h3C00};
        run_vec("s6", 16'h3C00, 5'd1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
